// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: flit ids, requester FSM states and the
// one-hot arbiter encoding used by both the requesters and the arbiter.
package noc_pkg;

    localparam int FLIT_ID_W = 3;
    localparam int LENGTH_W  = 12;

    localparam logic [FLIT_ID_W-1:0] FLIT_NONE   = 3'b000;
    localparam logic [FLIT_ID_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [FLIT_ID_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = 3'b100;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_REQUEST,
        REQ_SEND
    } req_state_e;

    // Port indices match the bit position of the port in the arbiter state, minus one.
    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    localparam logic [5:0] ARB_IDLE = 6'b000001;
    localparam logic [5:0] ARB_L    = 6'b000010;
    localparam logic [5:0] ARB_N    = 6'b000100;
    localparam logic [5:0] ARB_E    = 6'b001000;
    localparam logic [5:0] ARB_W    = 6'b010000;
    localparam logic [5:0] ARB_S    = 6'b100000;

    function automatic logic is_header(input logic [FLIT_ID_W-1:0] id);
        return id == FLIT_HEADER;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous FIFO with a combinational head view; head reads as zero when empty.
module flit_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/flit_requester.sv
// Per-port input requester: buffers flits, requests the arbiter and streams a
// packet while granted, re-requesting if the grant is withdrawn mid-packet.
module flit_requester
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_flit_id,
    input  logic [11:0]           in_length,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  grant,
    output logic                  req,
    output logic [2:0]            flit_id,
    output logic [11:0]           length,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  err
);

    localparam int FW = FLIT_ID_W + DATA_WIDTH;

    req_state_e        state_q, state_d;
    logic              started_q, started_d;
    logic [11:0]       length_q, length_d;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_head;

    assign in_ready = !rst && !fifo_full;
    assign push     = in_valid && in_ready;
    assign flit_id  = fifo_head[DATA_WIDTH +: FLIT_ID_W];
    assign out_data = fifo_head[DATA_WIDTH-1:0];
    assign length   = length_q;
    assign req      = (state_q != REQ_IDLE);

    flit_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_flit_id, in_data}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign length_d = (push && is_header(in_flit_id)) ? in_length : length_q;

    // started_q marks that this packet's own header has gone out, so a later
    // header at the head means the tail was lost.
    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        pop       = 1'b0;
        out_valid = 1'b0;
        err       = 1'b0;
        case (state_q)
            REQ_IDLE: begin
                if (!fifo_empty) begin
                    if (is_header(flit_id)) begin
                        state_d = REQ_REQUEST;
                    end else begin
                        pop = 1'b1;
                        err = 1'b1;
                    end
                end
            end
            REQ_REQUEST: begin
                if (grant) begin
                    state_d = REQ_SEND;
                end
            end
            REQ_SEND: begin
                if (!grant) begin
                    state_d = REQ_REQUEST;
                end else if (!fifo_empty) begin
                    if (is_header(flit_id) && started_q) begin
                        err       = 1'b1;
                        state_d   = REQ_IDLE;
                        started_d = 1'b0;
                    end else begin
                        pop       = 1'b1;
                        out_valid = 1'b1;
                        if (is_header(flit_id)) begin
                            started_d = 1'b1;
                        end else if (flit_id == FLIT_TAIL) begin
                            state_d   = REQ_IDLE;
                            started_d = 1'b0;
                        end else if (flit_id != FLIT_BODY) begin
                            err = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d   = REQ_IDLE;
                started_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= REQ_IDLE;
            started_q <= 1'b0;
            length_q  <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            length_q  <= length_d;
        end
    end

endmodule

// File: tb/tb_flit_requester.sv
// Directed bench for flit_requester: one task per scenario, cycle-indexed
// stimulus with hand-computed expectations.
module tb_flit_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_flit_id;
    logic [11:0] in_length;
    logic [31:0] in_data;
    logic        grant;
    logic        req;
    logic [2:0]  flit_id;
    logic [11:0] length;
    logic        out_valid;
    logic [31:0] out_data;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    flit_requester #(
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_flit_id (in_flit_id),
        .in_length  (in_length),
        .in_data    (in_data),
        .grant      (grant),
        .req        (req),
        .flit_id    (flit_id),
        .length     (length),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [2:0] id, input logic [11:0] len,
                          input logic [31:0] d);
        in_valid   = v;
        in_flit_id = id;
        in_length  = len;
        in_data    = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        grant = 1'b0;
        set_in(1'b0, 3'b000, 12'd0, 32'd0);
        next_cycle();
        next_cycle();
        #1;
        n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_tests++; if (flit_id !== 3'b000) begin n_fail++; $display("FAIL reset_flit_id: got %b expected 000", flit_id); end
        n_tests++; if (out_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_ov_err: got %b%b expected 00", out_valid, err); end
        n_tests++; if (out_data !== 32'd0 || length !== 12'd0) begin n_fail++; $display("FAIL reset_data_len: got %h/%0d expected 0/0", out_data, length); end
        rst = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
        next_cycle();
    endtask

    // H(len 20), B, B, T with grant held from the cycle req rises.
    task automatic test_basic();
        logic [2:0] exp_id [9] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b000, 3'b000};
        logic [2:0] ids [4]    = '{3'b001, 3'b010, 3'b010, 3'b100};
        for (int c = 0; c < 9; c++) begin
            if (c < 4) set_in(1'b1, ids[c], 12'd20, 32'hA0 + 32'(c));
            else       set_in(1'b0, 3'b000, 12'd0, 32'd0);
            grant = (c >= 2);
            #1;
            n_tests++; if (req !== (c >= 2 && c <= 6)) begin n_fail++; $display("FAIL basic_req c%0d: got %b expected %b", c, req, (c >= 2 && c <= 6)); end
            n_tests++; if (out_valid !== (c >= 3 && c <= 6)) begin n_fail++; $display("FAIL basic_out_valid c%0d: got %b expected %b", c, out_valid, (c >= 3 && c <= 6)); end
            n_tests++; if (flit_id !== exp_id[c]) begin n_fail++; $display("FAIL basic_flit_id c%0d: got %b expected %b", c, flit_id, exp_id[c]); end
            if (c >= 3 && c <= 6) begin
                $display("[TB] basic c%0d pop id=%b data=%h", c, flit_id, out_data);
                n_tests++; if (out_data !== 32'hA0 + 32'(c - 3)) begin n_fail++; $display("FAIL basic_out_data c%0d: got %h expected %h", c, out_data, 32'hA0 + 32'(c - 3)); end
            end
            if (c >= 1) begin
                n_tests++; if (length !== 12'd20) begin n_fail++; $display("FAIL basic_length c%0d: got %0d expected 20", c, length); end
            end
            n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err c%0d: got %b expected 0", c, err); end
            next_cycle();
        end
        grant = 1'b0;
    endtask

    // Grant withdrawn for 3 cycles after the 2nd flit.
    task automatic test_grant_drop();
        logic [2:0] exp_id [13] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
                                    3'b010, 3'b010, 3'b010, 3'b100, 3'b000, 3'b000};
        logic [2:0] ids [4] = '{3'b001, 3'b010, 3'b010, 3'b100};
        int k = 0;
        logic exp_ov;
        for (int c = 0; c < 13; c++) begin
            if (c < 4) set_in(1'b1, ids[c], 12'd20, 32'hB0 + 32'(c));
            else       set_in(1'b0, 3'b000, 12'd0, 32'd0);
            grant  = (c >= 2 && c <= 4) || (c >= 8);
            exp_ov = (c == 3) || (c == 4) || (c == 9) || (c == 10);
            #1;
            n_tests++; if (req !== (c >= 2 && c <= 10)) begin n_fail++; $display("FAIL drop_req c%0d: got %b expected %b", c, req, (c >= 2 && c <= 10)); end
            n_tests++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL drop_out_valid c%0d: got %b expected %b", c, out_valid, exp_ov); end
            n_tests++; if (flit_id !== exp_id[c]) begin n_fail++; $display("FAIL drop_flit_id c%0d: got %b expected %b", c, flit_id, exp_id[c]); end
            if (exp_ov) begin
                $display("[TB] drop c%0d pop id=%b data=%h", c, flit_id, out_data);
                n_tests++; if (out_data !== 32'hB0 + 32'(k)) begin n_fail++; $display("FAIL drop_out_data c%0d: got %h expected %h", c, out_data, 32'hB0 + 32'(k)); end
                k++;
            end
            next_cycle();
        end
        grant = 1'b0;
    endtask

    // Fill with grant low, attempt a 5th push, then drain.
    task automatic test_fill();
        logic [2:0] ids [4] = '{3'b001, 3'b010, 3'b010, 3'b100};
        logic exp_rdy;
        logic exp_ov;
        for (int c = 0; c < 12; c++) begin
            if (c < 4)       set_in(1'b1, ids[c], 12'd9, 32'hD0 + 32'(c));
            else if (c <= 6) set_in(1'b1, 3'b001, 12'd55, 32'hD4);
            else             set_in(1'b0, 3'b000, 12'd0, 32'd0);
            grant   = (c >= 5 && c <= 9);
            exp_rdy = !(c >= 4 && c <= 6);
            exp_ov  = (c >= 6 && c <= 9);
            #1;
            n_tests++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL fill_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy); end
            n_tests++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL fill_out_valid c%0d: got %b expected %b", c, out_valid, exp_ov); end
            if (exp_ov) begin
                $display("[TB] fill c%0d pop id=%b data=%h", c, flit_id, out_data);
                n_tests++; if (out_data !== 32'hD0 + 32'(c - 6)) begin n_fail++; $display("FAIL fill_out_data c%0d: got %h expected %h", c, out_data, 32'hD0 + 32'(c - 6)); end
            end
            if (c >= 10) begin
                n_tests++; if (flit_id !== 3'b000 || req !== 1'b0) begin n_fail++; $display("FAIL fill_drained c%0d: got id=%b req=%b expected id=000 req=0", c, flit_id, req); end
            end
            next_cycle();
        end
        n_tests++; if (length !== 12'd9) begin n_fail++; $display("FAIL fill_length: got %0d expected 9", length); end
        grant = 1'b0;
    endtask

    task automatic test_err_idle();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) set_in(1'b1, 3'b010, 12'd0, 32'hE0);
            else        set_in(1'b0, 3'b000, 12'd0, 32'd0);
            #1;
            n_tests++; if (err !== (c == 1)) begin n_fail++; $display("FAIL idle_err c%0d: got %b expected %b", c, err, (c == 1)); end
            n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL idle_req c%0d: got %b expected 0", c, req); end
            n_tests++; if (flit_id !== ((c == 1) ? 3'b010 : 3'b000)) begin n_fail++; $display("FAIL idle_flit_id c%0d: got %b expected %b", c, flit_id, ((c == 1) ? 3'b010 : 3'b000)); end
            if (c == 1) $display("[TB] idle c%0d drop id=%b err=%b", c, flit_id, err);
            next_cycle();
        end
    endtask

    // HA(len 7), BA, HB(len 33), TB with grant always high.
    task automatic test_missing_tail();
        logic [2:0]  ids [4] = '{3'b001, 3'b010, 3'b001, 3'b100};
        logic [11:0] lens [4] = '{12'd7, 12'd0, 12'd33, 12'd0};
        logic [31:0] exp_d [4] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        int k = 0;
        logic exp_req;
        logic exp_ov;
        grant = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 4) set_in(1'b1, ids[c], lens[c], 32'hC0 + 32'(c));
            else       set_in(1'b0, 3'b000, 12'd0, 32'd0);
            exp_req = (c >= 2 && c <= 5) || (c >= 7 && c <= 9);
            exp_ov  = (c == 3) || (c == 4) || (c == 8) || (c == 9);
            #1;
            n_tests++; if (err !== (c == 5)) begin n_fail++; $display("FAIL ntail_err c%0d: got %b expected %b", c, err, (c == 5)); end
            n_tests++; if (req !== exp_req) begin n_fail++; $display("FAIL ntail_req c%0d: got %b expected %b", c, req, exp_req); end
            n_tests++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL ntail_out_valid c%0d: got %b expected %b", c, out_valid, exp_ov); end
            if (exp_ov) begin
                $display("[TB] ntail c%0d pop id=%b data=%h", c, flit_id, out_data);
                n_tests++; if (out_data !== exp_d[k]) begin n_fail++; $display("FAIL ntail_out_data c%0d: got %h expected %h", c, out_data, exp_d[k]); end
                k++;
            end
            if (c == 2 || c == 7) begin
                n_tests++; if (length !== ((c == 2) ? 12'd7 : 12'd33)) begin n_fail++; $display("FAIL ntail_length c%0d: got %0d expected %0d", c, length, ((c == 2) ? 12'd7 : 12'd33)); end
            end
            next_cycle();
        end
        grant = 1'b0;
    endtask

    // H, B, B; reset asserted during SEND with the two bodies still buffered.
    task automatic test_reset_mid_send();
        logic [2:0] ids [3] = '{3'b001, 3'b010, 3'b010};
        for (int c = 0; c < 7; c++) begin
            if (c < 3) set_in(1'b1, ids[c], 12'd5, 32'hF0 + 32'(c));
            else       set_in(1'b0, 3'b000, 12'd0, 32'd0);
            grant = (c >= 2 && c <= 3);
            rst   = (c == 4);
            #1;
            if (c == 3) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== 32'hF0) begin n_fail++; $display("FAIL rstmid_first_pop: got ov=%b data=%h expected ov=1 data=000000f0", out_valid, out_data); end
            end
            if (c == 4) begin
                n_tests++; if (req !== 1'b1 || flit_id !== 3'b010) begin n_fail++; $display("FAIL rstmid_before: got req=%b id=%b expected req=1 id=010", req, flit_id); end
                n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready_in_rst: got %b expected 0", in_ready); end
            end
            if (c >= 5) begin
                $display("[TB] rstmid c%0d req=%b id=%b in_ready=%b", c, req, flit_id, in_ready);
                n_tests++; if (req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req c%0d: got %b expected 0", c, req); end
                n_tests++; if (flit_id !== 3'b000) begin n_fail++; $display("FAIL rstmid_flit_id c%0d: got %b expected 000", c, flit_id); end
                n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready c%0d: got %b expected 1", c, in_ready); end
                n_tests++; if (length !== 12'd0) begin n_fail++; $display("FAIL rstmid_length c%0d: got %0d expected 0", c, length); end
            end
            next_cycle();
        end
        rst   = 1'b0;
        grant = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_grant_drop();
        test_fill();
        test_err_idle();
        test_missing_tail();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flit_requester.md
# flit_requester

Input-port requester for the 5-port mesh router: buffers incoming flits for one port (L, N, E, W or S), raises the request line toward the router arbiter and presents the head flit's id and packet length. It streams flits out while its arbiter grant bit is high. If the grant is withdrawn mid-packet (arbiter timeout), it re-requests. One instance sits in front of each arbiter request input and drives that port's `req`, `flit_id` and `length`.

## Interface
- `DATA_WIDTH`, 32, payload bits per flit
- `DEPTH`, 4, flit buffer entries (power of two, ≥2)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream flit valid
- `in_ready`  out  1  buffer can accept a flit
- `in_flit_id`  in  3  flit type: 3'b001 header, 3'b010 body, 3'b100 tail
- `in_length`  in  12  packet timeout in clock periods; sampled with header flits only
- `in_data`  in  DATA_WIDTH  flit payload
- `grant`  in  1  this port's bit of the arbiter's registered state
- `req`  out  1  request to arbiter
- `flit_id`  out  3  id of head flit (3'b000 when buffer empty)
- `length`  out  12  length of the packet currently held
- `out_valid`  out  1  `out_data` transferred this cycle
- `out_data`  out  DATA_WIDTH  head flit payload
- `err`  out  1  one-cycle protocol-error pulse

## Operation
- Buffer: FIFO of {flit_id, data}. Push when `in_valid && in_ready`. `in_ready = !full`, with no push-while-full even if popping. There is no empty bypass: a written flit becomes visible at the head the next cycle. Pointers wrap modulo DEPTH. A count register of DEPTH+1 values distinguishes full from empty.
- `length_q` is loaded from `in_length` when a header is pushed. It is held until the next header push.
- States: IDLE, REQUEST, SEND.
- IDLE: `req=0`.
  - Head is header → REQUEST.
  - Head is non-header → pop it, pulse `err`, stay IDLE.
- REQUEST: `req=1`.
  - `grant=1` → SEND.
- SEND: `req=1`.
  - `grant=1` and non-empty: pop the head, `out_valid=1`.
  - Popped flit is tail → IDLE.
  - `grant=1` and empty: stall with `out_valid=0`, stay SEND.
  - `grant=0`: no pop, go to REQUEST (re-request; `flit_id` now shows body/tail).
  - Head is header before a tail was seen: no pop, pulse `err`, go to IDLE.
- Invalid ids (000, 011, 101, 110, 111) are treated as non-header in IDLE. In SEND they are popped as body with an `err` pulse.
- `flit_id`, `out_data`, `length` are combinational from the FIFO head and `length_q`. `req` is decoded from state only. `out_valid` depends on `grant`.

## Timing
- Reset values: state IDLE, FIFO empty, `length_q=0`, `req=0`, `out_valid=0`, `err=0`, `flit_id=0`, `out_data=0`.
  - `in_ready=0` while `rst` is high, and 1 in the first cycle after.
- Reset mid-packet: buffer flushed, `req` low next cycle.
- Header push at cycle t: head at t+1, state REQUEST at t+2, `req` high from t+2.
- Grant high at cycle g in REQUEST: first pop/`out_valid` at g+1.
  - Grant high at g in SEND: pop at g itself.
- Throughput: one flit per cycle while granted and non-empty.
- Tail popped at cycle k: `req` low at k+1. A following header already at the head raises `req` again at k+2, giving one idle request cycle between packets.
- Simultaneous push and pop when not full: both occur, count unchanged.

## Structure
- Shared package `noc_pkg`:
  - Flit-id constants `FLIT_HEADER`, `FLIT_BODY`, `FLIT_TAIL`, `FLIT_NONE`.
  - Requester state enum.
  - Port index / one-hot arbiter state constants (IDLE 6'b000001, L 6'b000010, N 6'b000100, E 6'b001000, W 6'b010000, S 6'b100000). These are shared with the arbiter.
- One sub-module, `flit_fifo`: parameterised sync FIFO (push/pop/full/empty/head). The FSM and length register stay in `flit_requester`.

## Test plan
- Reset then push header (length 12'd20), 2 body, tail; `grant` held high from the cycle `req` rises → `req` high 2 cycles after header push, 4 `out_valid` pulses on consecutive cycles, `req` low the cycle after tail, `length=20` throughout.
- Same packet, `grant` dropped for 3 cycles after the 2nd flit → state REQUEST with `req` high and `flit_id=3'b010`. On regrant the remaining 2 flits are sent in order, with no loss or duplication.
- Fill 4 flits with `grant=0` → `in_ready=0`, a 5th push is refused. Raise `grant` → `in_ready` returns to 1 after the first pop; order is preserved.
- Push body flit first while in IDLE → popped, `err` pulses once, `req` stays 0.
- Header, body, then a new header (no tail) while granted → `err` pulse on reaching the 2nd header, back to IDLE, then a request for the new packet with its new `length`.
- Assert `rst` for 1 cycle mid-SEND with 2 flits buffered → next cycle `req=0`, `flit_id=0`, buffer empty, `in_ready=1` after release.
